// File: rtl/graph_search_ctrl.sv
// -----------------------------------------------------------------------------
// graph_search_ctrl
//
// Sequences the BFS graph engine for one path query from the planner:
//   pose range check -> edge-mask snapshot -> forward sweep -> backward sweep
//   bounded by the forward depth -> response.
// Every sweep is guarded by a watchdog, and the host may cancel the query
// while it waits for the mask or while a sweep is being launched/running.
// The engine owns the edge RAM; this block only hands it a frozen mask.
//
// Ports
//   CLK, RST        clock (rising edge), synchronous active-high reset
//   req_*           planner query: req_valid/req_ready, start and end pose
//   cancel          host abort of the query in flight
//   mask_valid      collision checker says edge_mask is stable
//   edge_mask       1 = edge blocked
//   eng_mask        registered mask snapshot, frozen for the whole query
//   eng_start       1-cycle sweep start pulse
//   eng_dir         0 = forward sweep, 1 = backward sweep
//   eng_root/goal   sweep root and goal pose
//   eng_max_level   sweep level limit
//   eng_abort       1-cycle engine abort pulse
//   eng_done        1-cycle sweep finished pulse, qualifies eng_found/levels
//   rsp_*           planner response: rsp_valid/rsp_ready, status, levels
//   dbgState        current FSM state (debug observation only)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req_ready is high only in IDLE. rsp_valid is held, together with
// stable rsp_status/rsp_levels, until the edge where rsp_ready is seen high.
// -----------------------------------------------------------------------------
module graph_search_ctrl #(
    parameter int POSE_NUM    = 66,
    parameter int EDGE_NUM    = 1034,
    parameter int MAX_LEVEL   = 10,
    parameter int TIMEOUT_CYC = 16384
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [7:0]          req_start,
    input  logic [7:0]          req_end,
    input  logic                cancel,
    input  logic                mask_valid,
    input  logic [EDGE_NUM-1:0] edge_mask,
    output logic [EDGE_NUM-1:0] eng_mask,
    output logic                eng_start,
    output logic                eng_dir,
    output logic [7:0]          eng_root,
    output logic [7:0]          eng_goal,
    output logic [3:0]          eng_max_level,
    output logic                eng_abort,
    input  logic                eng_done,
    input  logic                eng_found,
    input  logic [3:0]          eng_levels,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [2:0]          rsp_status,
    output logic [3:0]          rsp_levels,
    output logic [2:0]          dbgState
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHECK     = 3'd1,
        WAIT_MASK = 3'd2,
        FWD_GO    = 3'd3,
        FWD_RUN   = 3'd4,
        BWD_GO    = 3'd5,
        BWD_RUN   = 3'd6,
        RESP      = 3'd7
    } state_t;

    localparam logic [2:0] ST_OK        = 3'd0;
    localparam logic [2:0] ST_NO_PATH   = 3'd1;
    localparam logic [2:0] ST_TIMEOUT   = 3'd2;
    localparam logic [2:0] ST_BAD_POSE  = 3'd3;
    localparam logic [2:0] ST_MISMATCH  = 3'd4;
    localparam logic [2:0] ST_CANCELLED = 3'd5;

    localparam int             WD_W       = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]     POSE_LIMIT = 8'(POSE_NUM);
    localparam logic [3:0]     MAX_LVL    = 4'(MAX_LEVEL);

    state_t          state;
    state_t          stateNext;
    logic [7:0]      startQ;
    logic [7:0]      endQ;
    logic [3:0]      levelQ;
    logic [WD_W-1:0] wdCnt;

    logic            respLoad;
    logic [2:0]      respStatusNext;
    logic [3:0]      respLevelsNext;
    logic            abortNext;
    logic            fwdLaunch;
    logic            bwdLaunch;
    logic            inGo;
    logic            inRun;
    logic            wdExpired;

    assign inGo      = (state == FWD_GO)  || (state == BWD_GO);
    assign inRun     = (state == FWD_RUN) || (state == BWD_RUN);
    assign wdExpired = (wdCnt == WD_LAST);

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    // A sweep cancelled in its launch cycle is never started, which is why
    // cancelling from a *_GO state needs no engine abort.
    assign eng_start = inGo && !cancel;
    assign dbgState  = state;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state and response/launch decisions.
    // Priority inside a *_RUN state: cancel, then eng_done, then watchdog.
    always_comb begin
        stateNext      = state;
        respLoad       = 1'b0;
        respStatusNext = ST_OK;
        respLevelsNext = 4'd0;
        abortNext      = 1'b0;
        fwdLaunch      = 1'b0;
        bwdLaunch      = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    stateNext = CHECK;
                end
            end
            CHECK: begin
                if ((startQ >= POSE_LIMIT) || (endQ >= POSE_LIMIT)) begin
                    stateNext      = RESP;
                    respLoad       = 1'b1;
                    respStatusNext = ST_BAD_POSE;
                end else if (startQ == endQ) begin
                    stateNext      = RESP;
                    respLoad       = 1'b1;
                    respStatusNext = ST_OK;
                end else begin
                    stateNext = WAIT_MASK;
                end
            end
            WAIT_MASK: begin
                if (cancel) begin
                    stateNext      = RESP;
                    respLoad       = 1'b1;
                    respStatusNext = ST_CANCELLED;
                end else if (mask_valid) begin
                    stateNext = FWD_GO;
                    fwdLaunch = 1'b1;
                end
            end
            FWD_GO, BWD_GO: begin
                if (cancel) begin
                    stateNext      = RESP;
                    respLoad       = 1'b1;
                    respStatusNext = ST_CANCELLED;
                end else begin
                    stateNext = (state == FWD_GO) ? FWD_RUN : BWD_RUN;
                end
            end
            FWD_RUN, BWD_RUN: begin
                if (cancel) begin
                    stateNext      = RESP;
                    respLoad       = 1'b1;
                    respStatusNext = ST_CANCELLED;
                    abortNext      = 1'b1;
                end else if (eng_done) begin
                    if (state == FWD_RUN) begin
                        if (eng_found) begin
                            stateNext = BWD_GO;
                            bwdLaunch = 1'b1;
                        end else begin
                            stateNext      = RESP;
                            respLoad       = 1'b1;
                            respStatusNext = ST_NO_PATH;
                        end
                    end else begin
                        stateNext = RESP;
                        respLoad  = 1'b1;
                        if (eng_found && (eng_levels == levelQ)) begin
                            respStatusNext = ST_OK;
                            respLevelsNext = levelQ;
                        end else begin
                            respStatusNext = ST_MISMATCH;
                        end
                    end
                end else if (wdExpired) begin
                    stateNext      = RESP;
                    respLoad       = 1'b1;
                    respStatusNext = ST_TIMEOUT;
                    abortNext      = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            startQ        <= 8'd0;
            endQ          <= 8'd0;
            levelQ        <= 4'd0;
            wdCnt         <= '0;
            eng_mask      <= '0;
            eng_dir       <= 1'b0;
            eng_root      <= 8'd0;
            eng_goal      <= 8'd0;
            eng_max_level <= 4'd0;
            eng_abort     <= 1'b0;
            rsp_status    <= ST_OK;
            rsp_levels    <= 4'd0;
        end else begin
            // Registered abort: the pulse lines up with the first RESP cycle.
            eng_abort <= abortNext;

            if (req_valid && req_ready) begin
                startQ <= req_start;
                endQ   <= req_end;
            end

            if (fwdLaunch) begin
                eng_mask      <= edge_mask;
                eng_dir       <= 1'b0;
                eng_root      <= startQ;
                eng_goal      <= endQ;
                eng_max_level <= MAX_LVL;
            end

            // Backward sweep is bounded by the depth the forward sweep used.
            if (bwdLaunch) begin
                levelQ        <= eng_levels;
                eng_dir       <= 1'b1;
                eng_root      <= endQ;
                eng_goal      <= startQ;
                eng_max_level <= eng_levels;
            end

            if (inGo) begin
                wdCnt <= '0;
            end else if (inRun) begin
                wdCnt <= wdCnt + 1'b1;
            end

            if (respLoad) begin
                rsp_status <= respStatusNext;
                rsp_levels <= respLevelsNext;
            end
        end
    end

endmodule

// File: tb/tb_graph_search_ctrl.sv
// -----------------------------------------------------------------------------
// tb_graph_search_ctrl
//
// Directed bench for graph_search_ctrl. Drivers push the expected response
// and the expected sweep launches into queues; monitors pop and compare
// whenever the DUT completes a response or pulses eng_start.
// -----------------------------------------------------------------------------
module tb_graph_search_ctrl;

    localparam int POSE_NUM    = 66;
    localparam int EDGE_NUM    = 1034;
    localparam int MAX_LEVEL   = 10;
    localparam int TIMEOUT_CYC = 16384;

    logic                CLK;
    logic                RST;
    logic                req_valid;
    logic                req_ready;
    logic [7:0]          req_start;
    logic [7:0]          req_end;
    logic                cancel;
    logic                mask_valid;
    logic [EDGE_NUM-1:0] edge_mask;
    logic [EDGE_NUM-1:0] eng_mask;
    logic                eng_start;
    logic                eng_dir;
    logic [7:0]          eng_root;
    logic [7:0]          eng_goal;
    logic [3:0]          eng_max_level;
    logic                eng_abort;
    logic                eng_done;
    logic                eng_found;
    logic [3:0]          eng_levels;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [2:0]          rsp_status;
    logic [3:0]          rsp_levels;
    logic [2:0]          dbgState;

    graph_search_ctrl #(
        .POSE_NUM   (POSE_NUM),
        .EDGE_NUM   (EDGE_NUM),
        .MAX_LEVEL  (MAX_LEVEL),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_start    (req_start),
        .req_end      (req_end),
        .cancel       (cancel),
        .mask_valid   (mask_valid),
        .edge_mask    (edge_mask),
        .eng_mask     (eng_mask),
        .eng_start    (eng_start),
        .eng_dir      (eng_dir),
        .eng_root     (eng_root),
        .eng_goal     (eng_goal),
        .eng_max_level(eng_max_level),
        .eng_abort    (eng_abort),
        .eng_done     (eng_done),
        .eng_found    (eng_found),
        .eng_levels   (eng_levels),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_status   (rsp_status),
        .rsp_levels   (rsp_levels),
        .dbgState     (dbgState)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #800000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // ---------------- scoreboard state ----------------
    logic [6:0]  exp_q[$];        // {status[2:0], levels[3:0]}
    logic [20:0] exp_start_q[$];  // {dir, root[7:0], goal[7:0], max_level[3:0]}
    int nCompared = 0;
    int nMismatch = 0;
    int startCnt  = 0;
    int abortCnt  = 0;

    logic [EDGE_NUM-1:0] maskA;
    logic [EDGE_NUM-1:0] maskB;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        nCompared++;
        if (act !== expv) begin
            nMismatch++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic logic [6:0] rspWord(input logic [2:0] st, input logic [3:0] lv);
        return {st, lv};
    endfunction

    function automatic logic [20:0] startWord(input logic d, input logic [7:0] r,
                                              input logic [7:0] g, input logic [3:0] m);
        return {d, r, g, m};
    endfunction

    // ---------------- monitors ----------------
    initial begin
        logic [6:0] e;
        forever begin
            @(negedge CLK);
            if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    nCompared++;
                    nMismatch++;
                    $display("FAIL unexpected_rsp: got status %0d levels %0d, none expected",
                             rsp_status, rsp_levels);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_status", 32'(rsp_status), 32'(e[6:4]));
                    check("rsp_levels", 32'(rsp_levels), 32'(e[3:0]));
                end
            end
        end
    end

    initial begin
        logic [20:0] e;
        forever begin
            @(negedge CLK);
            if (eng_start === 1'b1) begin
                startCnt++;
                if (exp_start_q.size() == 0) begin
                    nCompared++;
                    nMismatch++;
                    $display("FAIL unexpected_start: dir %0d root %0d goal %0d", eng_dir, eng_root, eng_goal);
                end else begin
                    e = exp_start_q.pop_front();
                    check("start_dir",   32'(eng_dir),       32'(e[20]));
                    check("start_root",  32'(eng_root),      32'(e[19:12]));
                    check("start_goal",  32'(eng_goal),      32'(e[11:4]));
                    check("start_maxlv", 32'(eng_max_level), 32'(e[3:0]));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (eng_abort === 1'b1) abortCnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic sendQuery(input logic [7:0] s, input logic [7:0] e);
        int n;
        @(posedge CLK);
        #1;
        req_start = s;
        req_end   = e;
        req_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge CLK);
            n++;
            if (req_ready === 1'b1) break;
            if (n > 50) begin
                check("req_ready_timeout", 32'(req_ready), 32'd1);
                break;
            end
        end
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic waitStart(output int n);
        n = 0;
        forever begin
            @(negedge CLK);
            n++;
            if (eng_start === 1'b1) break;
            if (n > 100) begin
                check("eng_start_timeout", 32'(eng_start), 32'd1);
                break;
            end
        end
    endtask

    task automatic doneAfter(input int n, input logic f, input logic [3:0] lv);
        repeat (n) @(posedge CLK);
        #1;
        eng_done   = 1'b1;
        eng_found  = f;
        eng_levels = lv;
        @(posedge CLK);
        #1;
        eng_done   = 1'b0;
        eng_found  = 1'b0;
        eng_levels = 4'd0;
    endtask

    task automatic waitDrain(input int bound);
        int n;
        n = 0;
        forever begin
            @(negedge CLK);
            #2;
            n++;
            if (exp_q.size() == 0) break;
            if (n > bound) begin
                check("rsp_drain_timeout", 32'(exp_q.size()), 32'd0);
                exp_q.delete();
                break;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int s0;
        int a0;

        maskA = EDGE_NUM'({33{32'hA5C3_0F1E}});
        maskB = ~maskA;

        RST        = 1'b1;
        req_valid  = 1'b0;
        req_start  = 8'd0;
        req_end    = 8'd0;
        cancel     = 1'b0;
        mask_valid = 1'b1;
        edge_mask  = maskA;
        eng_done   = 1'b0;
        eng_found  = 1'b0;
        eng_levels = 4'd0;
        rsp_ready  = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;

        // Reset values
        @(negedge CLK);
        check("rst_req_ready",  32'(req_ready),      32'd1);
        check("rst_rsp_valid",  32'(rsp_valid),      32'd0);
        check("rst_eng_start",  32'(eng_start),      32'd0);
        check("rst_eng_abort",  32'(eng_abort),      32'd0);
        check("rst_eng_dir",    32'(eng_dir),        32'd0);
        check("rst_eng_root",   32'(eng_root),       32'd0);
        check("rst_eng_goal",   32'(eng_goal),       32'd0);
        check("rst_eng_maxlv",  32'(eng_max_level),  32'd0);
        check("rst_rsp_status", 32'(rsp_status),     32'd0);
        check("rst_rsp_levels", 32'(rsp_levels),     32'd0);
        check("rst_eng_mask",   32'(eng_mask == '0), 32'd1);
        check("rst_dbg_state",  32'(dbgState),       32'd0);

        // Full query: 3 -> 40, forward found at 5, backward agrees
        exp_start_q.push_back(startWord(1'b0, 8'd3, 8'd40, 4'(MAX_LEVEL)));
        exp_start_q.push_back(startWord(1'b1, 8'd40, 8'd3, 4'd5));
        exp_q.push_back(rspWord(3'd0, 4'd5));
        sendQuery(8'd3, 8'd40);
        waitStart(n);
        check("ok_fwd_latency", 32'(n), 32'd3);
        check("ok_mask_snap", 32'(eng_mask == maskA), 32'd1);
        edge_mask = maskB;
        doneAfter(2, 1'b1, 4'd5);
        waitStart(n);
        check("ok_mask_frozen", 32'(eng_mask == maskA), 32'd1);
        doneAfter(3, 1'b1, 4'd5);
        waitDrain(50);
        edge_mask = maskA;

        // Bad start pose: response within 2 cycles, no sweep
        s0 = startCnt;
        exp_q.push_back(rspWord(3'd3, 4'd0));
        sendQuery(8'd70, 8'd5);
        n = 0;
        forever begin
            @(negedge CLK);
            n++;
            if (rsp_valid === 1'b1 || n > 10) break;
        end
        check("bad_latency_le2", 32'(n <= 2), 32'd1);
        waitDrain(50);
        check("bad_no_start", 32'(startCnt - s0), 32'd0);

        // Bad end pose at the boundary (66)
        exp_q.push_back(rspWord(3'd3, 4'd0));
        sendQuery(8'd1, 8'd66);
        waitDrain(50);

        // start == end: OK with zero levels, no sweep
        s0 = startCnt;
        exp_q.push_back(rspWord(3'd0, 4'd0));
        sendQuery(8'd12, 8'd12);
        waitDrain(50);
        check("same_no_start", 32'(startCnt - s0), 32'd0);

        // Highest legal pose, forward not found -> NO_PATH, no backward sweep
        s0 = startCnt;
        exp_start_q.push_back(startWord(1'b0, 8'd65, 8'd0, 4'(MAX_LEVEL)));
        exp_q.push_back(rspWord(3'd1, 4'd0));
        sendQuery(8'd65, 8'd0);
        waitStart(n);
        doneAfter(4, 1'b0, 4'd7);
        waitDrain(50);
        check("nopath_one_start", 32'(startCnt - s0), 32'd1);

        // Backward depth disagrees -> MISMATCH
        exp_start_q.push_back(startWord(1'b0, 8'd5, 8'd9, 4'(MAX_LEVEL)));
        exp_start_q.push_back(startWord(1'b1, 8'd9, 8'd5, 4'd5));
        exp_q.push_back(rspWord(3'd4, 4'd0));
        sendQuery(8'd5, 8'd9);
        waitStart(n);
        doneAfter(1, 1'b1, 4'd5);
        waitStart(n);
        doneAfter(2, 1'b1, 4'd4);
        waitDrain(50);

        // Watchdog: no eng_done at all -> one abort, TIMEOUT
        a0 = abortCnt;
        exp_start_q.push_back(startWord(1'b0, 8'd1, 8'd2, 4'(MAX_LEVEL)));
        exp_q.push_back(rspWord(3'd2, 4'd0));
        sendQuery(8'd1, 8'd2);
        waitStart(n);
        n = 0;
        forever begin
            @(negedge CLK);
            n++;
            if (eng_abort === 1'b1 || n > TIMEOUT_CYC + 100) break;
        end
        // TIMEOUT_CYC run cycles, abort registered into the first RESP cycle
        check("to_abort_cycle", 32'(n), 32'(TIMEOUT_CYC + 1));
        check("to_abort_with_rsp", 32'(rsp_valid), 32'd1);
        waitDrain(50);
        repeat (3) @(negedge CLK);
        check("to_one_abort", 32'(abortCnt - a0), 32'd1);

        // Cancel and eng_done in the same cycle -> CANCELLED with abort
        a0 = abortCnt;
        s0 = startCnt;
        exp_start_q.push_back(startWord(1'b0, 8'd7, 8'd8, 4'(MAX_LEVEL)));
        exp_q.push_back(rspWord(3'd5, 4'd0));
        sendQuery(8'd7, 8'd8);
        waitStart(n);
        @(posedge CLK);
        #1;
        cancel     = 1'b1;
        eng_done   = 1'b1;
        eng_found  = 1'b1;
        eng_levels = 4'd3;
        @(posedge CLK);
        #1;
        cancel     = 1'b0;
        eng_done   = 1'b0;
        eng_found  = 1'b0;
        eng_levels = 4'd0;
        waitDrain(50);
        repeat (3) @(negedge CLK);
        check("cxl_run_abort", 32'(abortCnt - a0), 32'd1);
        check("cxl_run_no_bwd", 32'(startCnt - s0), 32'd1);

        // Cancel while waiting for the mask: no sweep, no abort
        a0 = abortCnt;
        s0 = startCnt;
        mask_valid = 1'b0;
        exp_q.push_back(rspWord(3'd5, 4'd0));
        sendQuery(8'd4, 8'd6);
        repeat (3) @(posedge CLK);
        #1;
        cancel = 1'b1;
        @(posedge CLK);
        #1;
        cancel = 1'b0;
        waitDrain(50);
        mask_valid = 1'b1;
        repeat (3) @(negedge CLK);
        check("cxl_wait_no_abort", 32'(abortCnt - a0), 32'd0);
        check("cxl_wait_no_start", 32'(startCnt - s0), 32'd0);

        // Cancel and stray eng_done in IDLE are ignored
        @(posedge CLK);
        #1;
        cancel   = 1'b1;
        eng_done = 1'b1;
        @(posedge CLK);
        #1;
        cancel   = 1'b0;
        eng_done = 1'b0;
        @(negedge CLK);
        check("idle_ignore_ready", 32'(req_ready), 32'd1);
        check("idle_ignore_rsp",   32'(rsp_valid), 32'd0);

        // Response held while rsp_ready is low
        rsp_ready = 1'b0;
        exp_q.push_back(rspWord(3'd3, 4'd0));
        sendQuery(8'd100, 8'd3);
        n = 0;
        forever begin
            @(negedge CLK);
            n++;
            if (rsp_valid === 1'b1 || n > 10) break;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("hold_rsp_valid",  32'(rsp_valid),  32'd1);
            check("hold_rsp_status", 32'(rsp_status), 32'd3);
            check("hold_req_ready",  32'(req_ready),  32'd0);
        end
        @(posedge CLK);
        #1;
        rsp_ready = 1'b1;
        waitDrain(50);
        @(negedge CLK);
        check("hold_release_valid", 32'(rsp_valid), 32'd0);
        check("hold_release_ready", 32'(req_ready), 32'd1);

        // Reset in the middle of the forward sweep
        a0 = abortCnt;
        exp_start_q.push_back(startWord(1'b0, 8'd10, 8'd11, 4'(MAX_LEVEL)));
        sendQuery(8'd10, 8'd11);
        waitStart(n);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check("mid_rst_req_ready", 32'(req_ready),      32'd1);
        check("mid_rst_rsp_valid", 32'(rsp_valid),      32'd0);
        check("mid_rst_eng_root",  32'(eng_root),       32'd0);
        check("mid_rst_eng_goal",  32'(eng_goal),       32'd0);
        check("mid_rst_eng_maxlv", 32'(eng_max_level),  32'd0);
        check("mid_rst_eng_mask",  32'(eng_mask == '0), 32'd1);
        repeat (3) @(negedge CLK);
        check("mid_rst_no_abort", 32'(abortCnt - a0), 32'd0);

        // ---------------- final report ----------------
        repeat (2) @(negedge CLK);
        check("final_rsp_queue",   32'(exp_q.size()),       32'd0);
        check("final_start_queue", 32'(exp_start_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
